hdmi_audio_feeder: RTL
======================

Name: hdmi_audio_feeder

Overview:
- Upstream neighbour of the HDMI output selection stage, in the clk_pixel domain.
- Accepts stereo samples from the sound mixer at an arbitrary strobe rate and buffers them in a small FIFO.
- Generates the 48 kHz clk_audio from clk_pixel with a fractional accumulator (NCO).
- Presents a stable audio_sample_word pair that the HDMI audio packetiser samples on clk_audio rising edges.

Parameters:
- AUDIO_BIT_WIDTH, 16: sample width, legal range 16..24.
- CLK_HZ, 27_000_000: clk_pixel frequency in Hz.
- AUDIO_HZ, 48000: output sample rate in Hz.
- FIFO_DEPTH, 8: sample-pair entries; must be a power of two and at least 4.

Ports:
- clk_pixel  in  1  sole clock.
- reset_n  in  1  reset, asynchronous and active-low.
- sample_valid  in  1  one-cycle strobe; sample_l/sample_r are valid this cycle.
- sample_l  in  AUDIO_BIT_WIDTH  left sample, signed.
- sample_r  in  AUDIO_BIT_WIDTH  right sample, signed.
- mute  in  1  forces output words to 0; FIFO keeps draining.
- status_clear  in  1  clears the sticky flags.
- clk_audio  out  1  registered divided clock, nominal AUDIO_HZ.
- audio_sample_word  out  AUDIO_BIT_WIDTH x2  unpacked array [1:0]; [0]=left, [1]=right.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of entries.
- overrun  out  1  sticky: an input sample was dropped.
- underrun  out  1  sticky: a pop was needed but the FIFO was empty.

Behaviour:
- Reset values (async on reset_n=0):
  - clk_audio=0, audio_sample_word both 0, fifo_level=0, overrun=0, underrun=0.
  - NCO accumulator=0, FIFO pointers=0, state=FILLING.
- NCO:
  - 32-bit accumulator; each cycle acc += 2*AUDIO_HZ.
  - When the sum is >= CLK_HZ: acc = sum - CLK_HZ, assert one-cycle internal edge strobe, toggle clk_audio on the next edge.
  - Average toggle spacing is CLK_HZ/(2*AUDIO_HZ). At the defaults this is 281.25 cycles, so exactly 96 toggles per 27000 cycles.
- Fall tick: an edge strobe while clk_audio=1, i.e. clk_audio is going 1->0.
  - All output-word updates and FIFO pops happen only on fall ticks.
  - This keeps the word stable for at least a half period around each rising edge.
- FIFO:
  - Pointers carry an extra wrap bit; full = level==FIFO_DEPTH, empty = level==0.
  - Push: sample_valid=1 and (not full, or a pop occurs the same cycle).
  - Overflow: sample_valid=1 while full and no pop in that cycle -> sample discarded, overrun<=1.
  - Simultaneous push+pop: level unchanged. The popped entry is the oldest; no bypass from input to output.
  - fifo_level is registered and updated the cycle after the push/pop.
- State machine:
  - FILLING: fall ticks do not pop; audio_sample_word holds its last value. Move to RUNNING when level >= FIFO_DEPTH/2, evaluated on a fall tick; the pop happens on the next fall tick.
  - RUNNING: each fall tick pops one entry. On pop, audio_sample_word <= mute ? 0 : {popped_r, popped_l}.
  - Underrun: a fall tick in RUNNING with the FIFO empty holds the word (or writes 0 if mute), sets underrun<=1 and moves to FILLING.
- status_clear=1 clears overrun/underrun that cycle. A same-cycle set event wins.
- mute takes effect at the next fall tick, never mid-period.
- Reset mid-operation: everything returns immediately to the reset values; the FIFO contents are discarded.
- Latency: a sample pushed into an empty RUNNING-eligible FIFO reaches audio_sample_word at the first fall tick after it reaches the head, plus 0 extra cycles (updated on the tick's clock edge).

Decomposition:
- Shared package (hdmi_audio_pkg):
  - audio_pair_t: packed {r,l}, 2*AUDIO_BIT_WIDTH.
  - feeder_state_t enum {FILLING, RUNNING}.
  - NCO width constant NCO_W=32.
- One natural sub-module: audio_sample_fifo, a synchronous single-clock FIFO with level output. The NCO and state machine stay in the top.

Test Plan:
- NCO rate: reset, run 27000 cycles with defaults -> exactly 48 clk_audio rising edges; every high/low half is 281 or 282 cycles.
- Priming: push 3 samples in one burst -> no output change. Push a 4th -> state RUNNING at the next fall tick. Words appear in order on the following fall ticks: (L=0x0001,R=0x8001), (0x0002,0x8002), and so on.
- Overrun: with no fall tick pending, push 9 samples back-to-back -> fifo_level=8, overrun=1, 9th sample never output. status_clear -> overrun=0.
- Underrun: prime with 4, then stop input -> 4 distinct words output. 5th fall tick: word holds, underrun=1, state FILLING, no further change until level reaches 4 again.
- Mute and simultaneous events: mute=1 in RUNNING -> next fall-tick words=0 while fifo_level decrements. Push exactly on a pop cycle at full -> level stays 8, overrun stays 0.
- Async reset: assert reset_n=0 mid-period with clk_audio=1 -> clk_audio, words, fifo_level and flags are all 0 within the same cycle, with no clock edge required.

Source files
------------

// File: rtl/hdmi_audio_pkg.sv
// Shared types and constants for the HDMI audio feeder.
// The top rebuilds audio_pair_t at its own AUDIO_BIT_WIDTH; this copy is the default layout.
package hdmi_audio_pkg;

  localparam int unsigned NCO_W               = 32;
  localparam int unsigned AUDIO_BIT_WIDTH_DEF = 16;

  typedef struct packed {
    logic [AUDIO_BIT_WIDTH_DEF-1:0] r;
    logic [AUDIO_BIT_WIDTH_DEF-1:0] l;
  } audio_pair_t;

  typedef enum logic {
    FILLING = 1'b0,
    RUNNING = 1'b1
  } feeder_state_t;

  function automatic logic [NCO_W-1:0] nco_increment(input int unsigned audio_hz);
    return NCO_W'(2 * audio_hz);
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock FIFO with a registered occupancy count; the head entry is visible on o_rdata.
module audio_sample_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_push;
  logic              w_pop;

  // Pointers carry a wrap bit so full and empty are distinguishable when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/hdmi_audio_feeder.sv
// Buffers mixer samples, derives clk_audio from clk_pixel with an NCO and
// updates the output word only on clk_audio falling ticks.
module hdmi_audio_feeder
  import hdmi_audio_pkg::*;
#(
  parameter int unsigned AUDIO_BIT_WIDTH = 16,
  parameter int unsigned CLK_HZ          = 27_000_000,
  parameter int unsigned AUDIO_HZ        = 48000,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                              clk_pixel,
  input  logic                              reset_n,
  input  logic                              sample_valid,
  input  logic signed [AUDIO_BIT_WIDTH-1:0] sample_l,
  input  logic signed [AUDIO_BIT_WIDTH-1:0] sample_r,
  input  logic                              mute,
  input  logic                              status_clear,
  output logic                              clk_audio,
  output logic signed [AUDIO_BIT_WIDTH-1:0] audio_sample_word [1:0],
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              overrun,
  output logic                              underrun
);

  localparam int unsigned  LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned  PAIR_W  = 2 * AUDIO_BIT_WIDTH;
  localparam logic [NCO_W-1:0] NCO_INC = nco_increment(AUDIO_HZ);
  localparam logic [NCO_W-1:0] NCO_MOD = NCO_W'(CLK_HZ);
  localparam logic [LVL_W-1:0] LVL_START = LVL_W'(FIFO_DEPTH / 2);

  typedef struct packed {
    logic [AUDIO_BIT_WIDTH-1:0] r;
    logic [AUDIO_BIT_WIDTH-1:0] l;
  } pair_t;

  feeder_state_t    r_state;
  feeder_state_t    w_state_next;
  logic [NCO_W-1:0] r_acc;
  logic [NCO_W-1:0] w_sum;
  logic             r_edge;
  logic             r_clk_audio;
  pair_t            r_word;
  pair_t            w_word_next;
  pair_t            w_in_pair;
  pair_t            w_head;
  logic [LVL_W-1:0] w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_fall;
  logic             w_pop;
  logic             w_overflow;
  logic             w_underrun_set;
  logic             r_overrun;
  logic             r_underrun;

  assign w_in_pair = {sample_r, sample_l};

  audio_sample_fifo #(
    .DATA_W (PAIR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_pixel),
    .rst_n   (reset_n),
    .i_push  (sample_valid),
    .i_pop   (w_pop),
    .i_wdata (w_in_pair),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The accumulator stays below CLK_HZ, so the sum cannot wrap NCO_W bits.
  assign w_sum  = r_acc + NCO_INC;
  assign w_fall = r_edge & r_clk_audio;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_acc       <= '0;
      r_edge      <= 1'b0;
      r_clk_audio <= 1'b0;
    end else begin
      if (w_sum >= NCO_MOD) begin
        r_acc  <= w_sum - NCO_MOD;
        r_edge <= 1'b1;
      end else begin
        r_acc  <= w_sum;
        r_edge <= 1'b0;
      end
      r_clk_audio <= r_clk_audio ^ r_edge;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_word_next    = r_word;
    w_pop          = 1'b0;
    w_underrun_set = 1'b0;
    if (w_fall) begin
      unique case (r_state)
        FILLING: begin
          if (mute) begin
            w_word_next = '0;
          end
          if (w_level >= LVL_START) begin
            w_state_next = RUNNING;
          end
        end
        RUNNING: begin
          if (w_empty) begin
            if (mute) begin
              w_word_next = '0;
            end
            w_underrun_set = 1'b1;
            w_state_next   = FILLING;
          end else begin
            w_pop       = 1'b1;
            w_word_next = mute ? '0 : w_head;
          end
        end
        default: w_state_next = FILLING;
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a push at full is only dropped without one.
  assign w_overflow = sample_valid & w_full & ~w_pop;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= FILLING;
      r_word     <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_word  <= w_word_next;
      if (w_overflow) begin
        r_overrun <= 1'b1;
      end else if (status_clear) begin
        r_overrun <= 1'b0;
      end
      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end else if (status_clear) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign clk_audio            = r_clk_audio;
  assign audio_sample_word[0] = r_word.l;
  assign audio_sample_word[1] = r_word.r;
  assign fifo_level           = w_level;
  assign overrun              = r_overrun;
  assign underrun             = r_underrun;

endmodule
